bcd_shift_to_binary: RTL and testbench
======================================

BCD_SHIFT_TO_BINARY -- requirements
Module: bcd_shift_to_binary

Interface
REQ-001 SHALL have parameter N, default 10: binary result width in bits.
REQ-002 SHALL have derived constant D = (N/3)+1: BCD digit count, so bcd_in is 4*D bits wide (4 digits at N=10).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: conversion request, level-sampled.
REQ-006 SHALL have port bcd_in, input, 4*D bits: packed BCD operand, digit 0 in bits [3:0].
REQ-007 SHALL have port out, output, N bits: binary result, registered.
REQ-008 SHALL have port finish, output, 1 bit: result valid and held.
REQ-009 SHALL have port overflow, output, 1 bit: decimal value exceeds 2^N-1.
REQ-010 SHALL have port error, output, 1 bit: bcd_in held a digit greater than 9.

Function
REQ-011 SHALL implement states IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1 at edge t0 SHALL capture bcd_in into a 4*D-bit digit register, clear an N-bit binary register and an iteration counter, and go to SHIFT.
REQ-013 If any captured digit exceeds 9 at t0, the block SHALL go straight to DONE with out=0, error=1, overflow=0, and finish high from edge t0+1.
REQ-014 Each SHIFT cycle SHALL right-shift the concatenation {digits, binary} by one bit, then subtract 3 from every digit whose value is 8 or more (reverse double dabble), then increment the counter.
REQ-015 SHIFT SHALL run exactly N cycles, at edges t0+1 through t0+N; at edge t0+N, out SHALL load the final binary value and the state SHALL become DONE.
REQ-016 At DONE entry, overflow SHALL equal 1 when the residual digit register is nonzero; out SHALL then hold value mod 2^N.
REQ-017 finish SHALL be 1 exactly while in DONE; out, overflow and error SHALL stay stable throughout DONE.
REQ-018 DONE SHALL return to IDLE only on an edge where start=0, so a start held high never retriggers a conversion.
REQ-019 start and bcd_in changes during SHIFT SHALL be ignored.
REQ-020 In IDLE, out, overflow and error SHALL retain their last DONE values; they SHALL be cleared only by reset or a new capture.
REQ-021 Value 0 SHALL convert normally (out=0, full N-cycle latency, no flags).

Reset
REQ-022 reset=0 at any edge, including mid-SHIFT or in DONE, SHALL force IDLE and clear out, finish, overflow, error, the counter and both shift registers.
REQ-023 reset SHALL take precedence over start on the same edge.

Structure
REQ-024 The digit-count function D(N) and the state encoding SHALL live in shared package bcd_pkg, so the existing binary-to-BCD path uses the same D.
REQ-025 The per-digit correction (value of 8 or more: subtract 3) SHALL be a combinational sub-module named bcd_digit_adjust, instantiated D times.
REQ-026 The counter SHALL be clog2(N+1) bits wide.

Verification (N=10)
REQ-027 bcd_in=0x0675, start held high -> finish rises at edge t0+10, out=675, overflow=0, error=0; finish stays high until start drops.
REQ-028 bcd_in=0x1023 -> out=1023, overflow=0; then bcd_in=0x1024 -> out=0, overflow=1; bcd_in=0x9999 -> out=783, overflow=1.
REQ-029 bcd_in=0x0A12 -> finish at edge t0+1, error=1, out=0, overflow=0.
REQ-030 Back-to-back operands 0x0780 then 0x0169, each with start low for 2 cycles then high -> out=780 then 169, each at N-cycle latency, with no extra conversion while start stays high.
REQ-031 reset=0 at edge t0+5 of a conversion, then start re-asserted -> all outputs 0 immediately after the reset edge; the next conversion completes correctly at full latency.
REQ-032 bcd_in=0x0000 -> finish at edge t0+10, out=0, no flags.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit count for an N-bit binary value and the
// converter state encoding, used by both conversion directions.
package bcd_pkg;

    // Decimal digits needed to hold any N-bit binary value (one spare nibble
    // beyond the 3-bits-per-digit estimate).
    function automatic int bcd_digits(input int n);
        return (n / 3) + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD digit after a right shift:
// a digit of 8 or more had a borrowed half-ten shifted in, so subtract 3.
module bcd_digit_adjust (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd_shift_to_binary.sv
// Sequential BCD-to-binary converter: one bit per clock, N clocks per result,
// with overflow and invalid-digit flags held alongside the result.
module bcd_shift_to_binary
    import bcd_pkg::*;
#(
    parameter  int N = 10,
    localparam int D = bcd_digits(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [4*D-1:0] bcd_in,
    output logic [N-1:0]   out,
    output logic           finish,
    output logic           overflow,
    output logic           error
);

    localparam int DW = 4 * D;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    conv_state_t   state_q, state_d;
    logic [DW-1:0] digits_q, digits_d;
    logic [N-1:0]  bin_q, bin_d;
    logic [N-1:0]  out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic [DW+N-1:0] shifted;
    logic [DW-1:0]   adjusted;
    logic [D-1:0]    digit_bad;

    assign shifted = {digits_q, bin_q} >> 1;

    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_digit
            bcd_digit_adjust u_adjust (
                .digit_i (shifted[N + 4*gi +: 4]),
                .digit_o (adjusted[4*gi +: 4])
            );
            assign digit_bad[gi] = (digits_q[4*gi +: 4] > 4'd9);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        bin_d    = bin_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    digits_d = bcd_in;
                    bin_d    = '0;
                    cnt_d    = '0;
                    out_d    = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Invalid digits are judged on the freshly captured operand only.
                if ((cnt_q == '0) && (|digit_bad)) begin
                    out_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    digits_d = adjusted;
                    bin_d    = shifted[N-1:0];
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        out_d   = shifted[N-1:0];
                        ovf_d   = |adjusted;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            bin_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            bin_q    <= bin_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign out      = out_q;
    assign finish   = (state_q == ST_DONE);
    assign overflow = ovf_q;
    assign error    = err_q;

endmodule

// File: tb/tb_bcd_shift_to_binary.sv
// Directed bench for the BCD-to-binary converter at N=10.
module tb_bcd_shift_to_binary;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bcd_in;
    logic [9:0]  out;
    logic        finish;
    logic        overflow;
    logic        error;

    int total = 0;
    int bad   = 0;

    bcd_shift_to_binary #(.N(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bcd_in   (bcd_in),
        .out      (out),
        .finish   (finish),
        .overflow (overflow),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic run_conv(input logic [15:0] bcd, input logic [9:0] exp_out,
                            input logic exp_ovf, input logic exp_err, input int exp_lat);
        int lat;
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bcd_in = 16'hFFFF;
        lat = 0;
        while (!finish && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("conv bcd=%h lat=%0d out=%0d ovf=%0d err=%0d", bcd, lat, out, overflow, error);
        check_val("latency", lat, exp_lat);
        check_val("out", out, exp_out);
        check_val("overflow", overflow, exp_ovf);
        check_val("error", error, exp_err);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("finish_held", finish, 1'b1);
            check_val("out_held", out, exp_out);
        end
        start  = 1'b0;
        bcd_in = bcd;
        @(negedge clk);
        check_val("finish_idle", finish, 1'b0);
        check_val("out_idle", out, exp_out);
        check_val("ovf_idle", overflow, exp_ovf);
        check_val("err_idle", error, exp_err);
        @(negedge clk);
    endtask

    initial begin
        bit fin_seen;
        reset  = 1'b0;
        start  = 1'b0;
        bcd_in = 16'h0000;
        repeat (3) @(negedge clk);
        check_val("rst_out", out, 10'd0);
        check_val("rst_finish", finish, 1'b0);
        check_val("rst_ovf", overflow, 1'b0);
        check_val("rst_err", error, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        run_conv(16'h0675, 10'd675, 1'b0, 1'b0, 10);

        // Reset and start on the same edge: reset must win, no conversion.
        @(negedge clk);
        reset  = 1'b0;
        start  = 1'b1;
        bcd_in = 16'h0321;
        @(negedge clk);
        check_val("prec_out", out, 10'd0);
        check_val("prec_finish", finish, 1'b0);
        reset = 1'b1;
        start = 1'b0;
        fin_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (finish) fin_seen = 1'b1;
        end
        check_val("prec_no_conv", fin_seen, 1'b0);

        run_conv(16'h1023, 10'd1023, 1'b0, 1'b0, 10);
        run_conv(16'h1024, 10'd0,    1'b1, 1'b0, 10);
        run_conv(16'h9999, 10'd783,  1'b1, 1'b0, 10);

        // Reset while sitting in DONE with overflow set.
        @(negedge clk);
        bcd_in = 16'h9999;
        start  = 1'b1;
        repeat (11) @(negedge clk);
        check_val("done_finish", finish, 1'b1);
        check_val("done_ovf", overflow, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_val("rdone_finish", finish, 1'b0);
        check_val("rdone_out", out, 10'd0);
        check_val("rdone_ovf", overflow, 1'b0);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);

        run_conv(16'h0A12, 10'd0, 1'b0, 1'b1, 1);
        run_conv(16'h0780, 10'd780, 1'b0, 1'b0, 10);
        run_conv(16'h0169, 10'd169, 1'b0, 1'b0, 10);

        // Reset at edge t0+5 of a conversion, then a full conversion.
        @(negedge clk);
        bcd_in = 16'h0780;
        start  = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rmid_finish", finish, 1'b0);
        check_val("rmid_out", out, 10'd0);
        check_val("rmid_ovf", overflow, 1'b0);
        check_val("rmid_err", error, 1'b0);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        run_conv(16'h0780, 10'd780, 1'b0, 1'b0, 10);

        run_conv(16'h0000, 10'd0, 1'b0, 1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
